// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-panel controller: debounces the start/stop and lap/clear keys
// and runs the IDLE/RUNNING/LAP/STOPPED mode FSM that drives the datapath and display.

module stopwatch_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic key_n,
    output logic press
);

    localparam logic [19:0] CNT_LAST = 20'(DEBOUNCE_CYCLES - 1);

    logic        sync1_q;
    logic        sync2_q;
    logic        level_q;
    logic        level_d;
    logic        level_dly_q;
    logic [19:0] cnt_q;
    logic [19:0] cnt_d;
    logic        press_q;

    // Keys idle high, so the synchronizer comes out of reset already "released".
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 20'd1;
            end
        end
    end

    // The press pulse compares the debounced level with its delayed copy, so it
    // lands one cycle after the debounced level falls and never on a release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            level_q     <= 1'b1;
            level_dly_q <= 1'b1;
            press_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
            press_q     <= level_dly_q & ~level_q;
        end
    end

    assign press = press_q;

endmodule

module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        key_start_n,
    input  logic        key_lap_n,
    input  logic [17:0] epoch,
    input  logic [7:0]  m_epoch,
    output logic        run,
    output logic        clear,
    output logic        frozen,
    output logic [17:0] disp_epoch,
    output logic [7:0]  disp_m_epoch,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        LAP     = 2'd2,
        STOPPED = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        run_q;
    logic        run_d;
    logic        frozen_q;
    logic        frozen_d;
    logic        clear_q;
    logic        clear_d;
    logic [17:0] disp_epoch_q;
    logic [7:0]  disp_m_epoch_q;
    logic        start_evt;
    logic        lap_evt;

    stopwatch_key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_start_db (
        .clock  (clock),
        .reset_n(reset_n),
        .key_n  (key_start_n),
        .press  (start_evt)
    );

    stopwatch_key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_lap_db (
        .clock  (clock),
        .reset_n(reset_n),
        .key_n  (key_lap_n),
        .press  (lap_evt)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Start is checked first in every state so a simultaneous lap press is dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_evt) state_d = RUNNING;
            end
            RUNNING: begin
                if (start_evt)    state_d = STOPPED;
                else if (lap_evt) state_d = LAP;
            end
            LAP: begin
                if (start_evt)    state_d = STOPPED;
                else if (lap_evt) state_d = RUNNING;
            end
            STOPPED: begin
                if (start_evt)    state_d = RUNNING;
                else if (lap_evt) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up
    // with the state register on the same edge.
    always_comb begin
        run_d    = (state_d == RUNNING) || (state_d == LAP);
        frozen_d = (state_d == LAP);
        clear_d  = lap_evt && !start_evt &&
                   ((state_q == IDLE) || (state_q == STOPPED));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run_q    <= 1'b0;
            frozen_q <= 1'b0;
            clear_q  <= 1'b0;
        end else begin
            run_q    <= run_d;
            frozen_q <= frozen_d;
            clear_q  <= clear_d;
        end
    end

    // Display tracks the datapath unless frozen; the RUNNING->LAP edge still
    // loads because frozen_q is low then, which is what captures the lap value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            disp_epoch_q   <= '0;
            disp_m_epoch_q <= '0;
        end else if (!frozen_q) begin
            disp_epoch_q   <= epoch;
            disp_m_epoch_q <= m_epoch;
        end
    end

    assign run          = run_q;
    assign frozen       = frozen_q;
    assign clear        = clear_q;
    assign disp_epoch   = disp_epoch_q;
    assign disp_m_epoch = disp_m_epoch_q;
    assign state        = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a 4-cycle debounce; each scenario task
// drives keys on the falling clock edge and checks outputs there against hand-derived values.

module tb_stopwatch_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        key_start_n;
    logic        key_lap_n;
    logic [17:0] epoch;
    logic [7:0]  m_epoch;
    logic        run;
    logic        clear;
    logic        frozen;
    logic [17:0] disp_epoch;
    logic [7:0]  disp_m_epoch;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    stopwatch_ctrl #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .key_start_n (key_start_n),
        .key_lap_n   (key_lap_n),
        .epoch       (epoch),
        .m_epoch     (m_epoch),
        .run         (run),
        .clear       (clear),
        .frozen      (frozen),
        .disp_epoch  (disp_epoch),
        .disp_m_epoch(disp_m_epoch),
        .state       (state)
    );

    // Press both/one key for 'hold' cycles then let the release debounce settle.
    task automatic pressKeys(input bit s, input bit l, input int hold);
        key_start_n = ~s;
        key_lap_n   = ~l;
        repeat (hold) @(negedge clock);
        key_start_n = 1'b1;
        key_lap_n   = 1'b1;
        repeat (12) @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        key_start_n = 1'b1;
        key_lap_n   = 1'b1;
        epoch       = 18'h3F0F0;
        m_epoch     = 8'h55;
        repeat (3) @(negedge clock);
        checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL reset_state got %0d want 0", state); end
        checks++; if (run !== 1'b0) begin errors++; $display("[TB] FAIL reset_run got %b want 0", run); end
        checks++; if (clear !== 1'b0) begin errors++; $display("[TB] FAIL reset_clear got %b want 0", clear); end
        checks++; if (frozen !== 1'b0) begin errors++; $display("[TB] FAIL reset_frozen got %b want 0", frozen); end
        checks++; if (disp_epoch !== 18'h0) begin errors++; $display("[TB] FAIL reset_disp got %h want 0", disp_epoch); end
        checks++; if (disp_m_epoch !== 8'h0) begin errors++; $display("[TB] FAIL reset_disp_m got %h want 0", disp_m_epoch); end
        reset_n = 1'b1;
        repeat (10) @(negedge clock);
        checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL release_state got %0d want 0", state); end
        checks++; if (disp_epoch !== 18'h3F0F0) begin errors++; $display("[TB] FAIL live_disp got %h want 3f0f0", disp_epoch); end
        checks++; if (disp_m_epoch !== 8'h55) begin errors++; $display("[TB] FAIL live_disp_m got %h want 55", disp_m_epoch); end
    endtask

    task automatic test_start_debounce();
        key_start_n = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (c == 7) begin
                checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL start_early got %0d want 0", state); end
            end
            if (c == 8) begin
                checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL start_state got %0d want 1", state); end
                checks++; if (run !== 1'b1) begin errors++; $display("[TB] FAIL start_run got %b want 1", run); end
                checks++; if (frozen !== 1'b0) begin errors++; $display("[TB] FAIL start_frozen got %b want 0", frozen); end
            end
        end
        key_start_n = 1'b1;
        repeat (12) @(negedge clock);
        checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL start_release got %0d want 1", state); end
    endtask

    task automatic test_glitch();
        bit sawClear;
        sawClear  = 1'b0;
        key_lap_n = 1'b0;
        repeat (3) @(negedge clock);
        key_lap_n = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            if (clear) sawClear = 1'b1;
        end
        checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL glitch_state got %0d want 1", state); end
        checks++; if (sawClear !== 1'b0) begin errors++; $display("[TB] FAIL glitch_clear got %b want 0", sawClear); end
    endtask

    task automatic test_lap();
        epoch     = 18'h01083;
        m_epoch   = 8'd42;
        key_lap_n = 1'b0;
        // Exactly four low cycles: the shortest press that debounces.
        for (int c = 1; c <= 18; c++) begin
            @(negedge clock);
            if (c == 4) key_lap_n = 1'b1;
            if (c == 7) begin
                checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL lap_early got %0d want 1", state); end
            end
            if (c == 8) begin
                checks++; if (state !== 2'd2) begin errors++; $display("[TB] FAIL lap_state got %0d want 2", state); end
                checks++; if (frozen !== 1'b1) begin errors++; $display("[TB] FAIL lap_frozen got %b want 1", frozen); end
                checks++; if (run !== 1'b1) begin errors++; $display("[TB] FAIL lap_run got %b want 1", run); end
                checks++; if (disp_epoch !== 18'h01083) begin errors++; $display("[TB] FAIL lap_capture got %h want 01083", disp_epoch); end
                epoch   = 18'h2AAAA;
                m_epoch = 8'd99;
            end
            if (c == 12) begin
                checks++; if (disp_epoch !== 18'h01083) begin errors++; $display("[TB] FAIL lap_hold got %h want 01083", disp_epoch); end
                checks++; if (disp_m_epoch !== 8'd42) begin errors++; $display("[TB] FAIL lap_hold_m got %0d want 42", disp_m_epoch); end
            end
        end
        key_lap_n = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (c == 8) begin
                checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL unlap_state got %0d want 1", state); end
                checks++; if (frozen !== 1'b0) begin errors++; $display("[TB] FAIL unlap_frozen got %b want 0", frozen); end
                checks++; if (disp_epoch !== 18'h01083) begin errors++; $display("[TB] FAIL unlap_edge got %h want 01083", disp_epoch); end
            end
            if (c == 9) begin
                checks++; if (disp_epoch !== 18'h2AAAA) begin errors++; $display("[TB] FAIL unlap_live got %h want 2aaaa", disp_epoch); end
                checks++; if (disp_m_epoch !== 8'd99) begin errors++; $display("[TB] FAIL unlap_live_m got %0d want 99", disp_m_epoch); end
            end
        end
        key_lap_n = 1'b1;
        repeat (12) @(negedge clock);
    endtask

    task automatic test_stop_clear();
        key_start_n = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (c == 8) begin
                checks++; if (state !== 2'd3) begin errors++; $display("[TB] FAIL stop_state got %0d want 3", state); end
                checks++; if (run !== 1'b0) begin errors++; $display("[TB] FAIL stop_run got %b want 0", run); end
            end
        end
        key_start_n = 1'b1;
        repeat (12) @(negedge clock);
        key_lap_n = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (c == 7) begin
                checks++; if (clear !== 1'b0) begin errors++; $display("[TB] FAIL clear_early got %b want 0", clear); end
            end
            if (c == 8) begin
                checks++; if (clear !== 1'b1) begin errors++; $display("[TB] FAIL clear_pulse got %b want 1", clear); end
                checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL clear_state got %0d want 0", state); end
                checks++; if (run !== 1'b0) begin errors++; $display("[TB] FAIL clear_run got %b want 0", run); end
            end
            if (c == 9) begin
                checks++; if (clear !== 1'b0) begin errors++; $display("[TB] FAIL clear_width got %b want 0", clear); end
            end
        end
        key_lap_n = 1'b1;
        repeat (12) @(negedge clock);
    endtask

    task automatic test_back_to_back();
        key_start_n = 1'b0;
        key_lap_n   = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (c == 8) begin
                checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL both_idle_state got %0d want 1", state); end
                checks++; if (clear !== 1'b0) begin errors++; $display("[TB] FAIL both_idle_clear got %b want 0", clear); end
            end
        end
        key_start_n = 1'b1;
        key_lap_n   = 1'b1;
        repeat (12) @(negedge clock);
        key_start_n = 1'b0;
        key_lap_n   = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (c == 8) begin
                checks++; if (state !== 2'd3) begin errors++; $display("[TB] FAIL both_run_state got %0d want 3", state); end
                checks++; if (frozen !== 1'b0) begin errors++; $display("[TB] FAIL both_run_frozen got %b want 0", frozen); end
                checks++; if (clear !== 1'b0) begin errors++; $display("[TB] FAIL both_run_clear got %b want 0", clear); end
            end
            if (c == 9) begin
                checks++; if (state !== 2'd3) begin errors++; $display("[TB] FAIL both_run_after got %0d want 3", state); end
            end
        end
        key_start_n = 1'b1;
        key_lap_n   = 1'b1;
        repeat (12) @(negedge clock);
    endtask

    task automatic test_reset_mid();
        pressKeys(1'b1, 1'b0, 10);
        checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL rm_run got %0d want 1", state); end
        pressKeys(1'b0, 1'b1, 10);
        checks++; if (state !== 2'd2) begin errors++; $display("[TB] FAIL rm_lap got %0d want 2", state); end
        key_start_n = 1'b0;
        repeat (4) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL rm_state got %0d want 0", state); end
        checks++; if (run !== 1'b0) begin errors++; $display("[TB] FAIL rm_run_out got %b want 0", run); end
        checks++; if (frozen !== 1'b0) begin errors++; $display("[TB] FAIL rm_frozen got %b want 0", frozen); end
        checks++; if (clear !== 1'b0) begin errors++; $display("[TB] FAIL rm_clear got %b want 0", clear); end
        checks++; if (disp_epoch !== 18'h0) begin errors++; $display("[TB] FAIL rm_disp got %h want 0", disp_epoch); end
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (c == 7) begin
                checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL rm_held_early got %0d want 0", state); end
            end
            if (c == 8) begin
                checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL rm_held_press got %0d want 1", state); end
            end
        end
        checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL rm_held_once got %0d want 1", state); end
        key_start_n = 1'b1;
        repeat (12) @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_start_debounce();
        test_glitch();
        test_lap();
        test_stop_clear();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, meaning: consecutive stable clocks required to accept a key level change (20 ms at 50 MHz); legal range 1..2^20-1.
REQ-002 clock  input  1  system clock; all state updates on rising edge; single clock domain.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 key_start_n  input  1  raw start/stop push-button, active-low, asynchronous to clock.
REQ-005 key_lap_n  input  1  raw lap/clear push-button, active-low, asynchronous to clock.
REQ-006 epoch  input  18  live {hour,minute,second} from stopwatch datapath, 6 bits each.
REQ-007 m_epoch  input  8  live hundredths from stopwatch datapath.
REQ-008 run  output  1  enable to stopwatch datapath; registered.
REQ-009 clear  output  1  active-high one-cycle reset pulse to stopwatch datapath; registered.
REQ-010 frozen  output  1  high while display is held at lap value; registered.
REQ-011 disp_epoch  output  18  displayed {hour,minute,second}; registered.
REQ-012 disp_m_epoch  output  8  displayed hundredths; registered.
REQ-013 state  output  2  FSM state: IDLE=0, RUNNING=1, LAP=2, STOPPED=3.

Function
REQ-014 Each key SHALL pass through a 2-flop synchronizer; sync flops reset to 1 (released).
REQ-015 Per key, a 20-bit counter SHALL increment each cycle the synchronized level differs from the debounced level, and clear to 0 when equal.
REQ-016 When the counter equals DEBOUNCE_CYCLES-1 and levels still differ, the debounced level SHALL flip on the next edge and the counter SHALL clear.
REQ-017 A press event SHALL be a registered one-cycle pulse, asserted the cycle after the debounced level goes 1->0; release (0->1) SHALL generate no event.
REQ-018 A key held low indefinitely SHALL produce exactly one press event; glitches shorter than DEBOUNCE_CYCLES SHALL produce none.
REQ-019 FSM SHALL update on the edge following a press-event pulse; outputs run/frozen/state reflect the new state in that same cycle.
REQ-020 IDLE: run=0, frozen=0; start -> RUNNING; lap -> assert clear one cycle, remain IDLE.
REQ-021 RUNNING: run=1, frozen=0; start -> STOPPED; lap -> LAP, capturing epoch/m_epoch into disp registers on the transition edge.
REQ-022 LAP: run=1, frozen=1, disp registers hold captured value; start -> STOPPED; lap -> RUNNING.
REQ-023 STOPPED: run=0, frozen=0; start -> RUNNING; lap -> IDLE with clear asserted one cycle.
REQ-024 Simultaneous start and lap events in one cycle: start SHALL take effect, lap SHALL be discarded.
REQ-025 When frozen=0, disp_epoch/disp_m_epoch SHALL load epoch/m_epoch every cycle (1-cycle latency); when frozen=1, they SHALL hold.
REQ-026 Leaving LAP (either key) SHALL resume live display on the next cycle.
REQ-027 clear SHALL never assert in RUNNING or LAP; clear SHALL be high for exactly one cycle per qualifying event.
REQ-028 Unused encodings are impossible; any illegal state value SHALL transition to IDLE.

Reset
REQ-029 reset_n low SHALL asynchronously force: state=IDLE, run=0, clear=0, frozen=0, disp_epoch=0, disp_m_epoch=0, debounce counters=0, debounced levels=1, event pulses=0.
REQ-030 Reset asserted mid-debounce or in LAP SHALL discard partial counts and held values; after release, a key already held low SHALL register one press after full debounce.
REQ-031 Deassertion of reset_n is assumed synchronized externally; no event SHALL be generated by reset release alone.

Verification (DEBOUNCE_CYCLES=4)
REQ-032 Reset, then key_start_n low 10 cycles -> one press pulse 7 cycles after falling edge (2 sync + 4 debounce + 1), state IDLE->RUNNING, run=1.
REQ-033 key_lap_n low 3 cycles then high -> no event, state unchanged, clear=0.
REQ-034 RUNNING with epoch=0x01083 m_epoch=42, press lap -> state=LAP, frozen=1, disp holds 0x01083/42 while inputs change; press lap again -> live display next cycle.
REQ-035 STOPPED, press lap -> clear high exactly 1 cycle, state=IDLE, run=0.
REQ-036 Both keys pressed same cycle in RUNNING -> STOPPED, no LAP entry, no clear.
REQ-037 Assert reset_n low in LAP mid-debounce of start -> all outputs 0, state IDLE immediately (no clock edge needed).
